// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the fabric-to-PPC snapshot register: word map,
// control/status bit positions, slave FSM states and bus bit-order helper.
package opb_s2p_pkg;

    localparam logic [1:0] WORD_DATA   = 2'd0;
    localparam logic [1:0] WORD_STATUS = 2'd1;
    localparam logic [1:0] WORD_CTRL   = 2'd2;

    localparam int CTRL_FREEZE  = 0;
    localparam int CTRL_CLR_OVR = 1;
    localparam int CTRL_CLR_CNT = 2;

    localparam int STAT_FRESH   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_FREEZE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ack_state_t;

    // OPB numbers bits big-endian: value bit k lives on bus bit 31-k.
    function automatic logic [0:31] to_opb(input logic [31:0] value);
        logic [0:31] bus;
        bus = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            bus[31-k] = value[k];
        end
        return bus;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and one-ack-per-select handshake for the OPB slave.
// ack_req/rd_en/wr_en are single-cycle strobes on the edge that accepts a transfer.
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_3900,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_39FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic [0:31] abus,
    input  logic        rnw,
    output logic        ack_req,
    output logic        rd_en,
    output logic        wr_en,
    output logic [1:0]  word
);

    ack_state_t state_r;
    ack_state_t state_next_s;
    logic       hit_s;
    logic       accept_s;

    assign hit_s    = select & (abus >= C_BASEADDR) & (abus <= C_HIGHADDR);
    assign accept_s = (state_r == ST_IDLE) & hit_s;
    assign ack_req  = accept_s;
    assign rd_en    = accept_s & rnw;
    assign wr_en    = accept_s & ~rnw;
    assign word     = abus[28:29];

    // State register; reset returns the slave to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: ack once, then wait for the master to release select.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) state_next_s = ST_ACK;
                else       state_next_s = ST_IDLE;
            end
            ST_ACK: begin
                if (select) state_next_s = ST_HOLD;
                else        state_next_s = ST_IDLE;
            end
            ST_HOLD: begin
                if (select) state_next_s = ST_HOLD;
                else        state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC snapshot register. User logic strobes words in; the PPC reads
// the latest word plus a status word (fresh/overrun/freeze/update count).
module opb_register_simulink2ppc_snap
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_3900,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_39FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          CNT_W        = 16
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid
);

    logic [31:0]      snapshot_r;
    logic             fresh_r, overrun_r, freeze_r;
    logic [CNT_W-1:0] cnt_r;

    logic             ack_req_s, rd_en_s, wr_en_s;
    logic [1:0]       word_s;
    logic             ctrl_wr_s, clr_ovr_s, clr_cnt_s, capture_s, data_rd_s;
    logic             fresh_next_s, overrun_next_s, freeze_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [15:0]      cnt16_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Only the LS byte lane carries control bits; bursts are not supported.
    assign unused_s = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:28], |C_FAMILY,
                        (C_OPB_AWIDTH == 32'sd32), (C_OPB_DWIDTH == 32'sd32)};

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk     (OPB_Clk),
        .rst     (OPB_Rst),
        .select  (OPB_select),
        .abus    (OPB_ABus),
        .rnw     (OPB_RNW),
        .ack_req (ack_req_s),
        .rd_en   (rd_en_s),
        .wr_en   (wr_en_s),
        .word    (word_s)
    );

    assign ctrl_wr_s = wr_en_s & (word_s == WORD_CTRL) & OPB_BE[3];
    assign clr_ovr_s = ctrl_wr_s & OPB_DBus[31-CTRL_CLR_OVR];
    assign clr_cnt_s = ctrl_wr_s & OPB_DBus[31-CTRL_CLR_CNT];
    assign capture_s = user_valid & ~freeze_r;
    assign data_rd_s = rd_en_s & (word_s == WORD_DATA);
    assign cnt16_s   = 16'(cnt_r);

    // Flag/counter update rules: capture beats a read clear, set beats clear.
    always_comb begin
        fresh_next_s   = fresh_r;
        overrun_next_s = overrun_r;
        freeze_next_s  = freeze_r;
        cnt_next_s     = cnt_r;
        if (capture_s) begin
            fresh_next_s = 1'b1;
        end else if (data_rd_s) begin
            fresh_next_s = 1'b0;
        end else begin
            fresh_next_s = fresh_r;
        end
        overrun_next_s = (capture_s & fresh_r & ~data_rd_s) | (overrun_r & ~clr_ovr_s);
        if (clr_cnt_s) begin
            cnt_next_s = capture_s ? CNT_W'(1) : CNT_W'(0);
        end else if (capture_s) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        if (ctrl_wr_s) begin
            freeze_next_s = OPB_DBus[31-CTRL_FREEZE];
        end else begin
            freeze_next_s = freeze_r;
        end
    end

    // Read mux over the register contents present at the accepting edge.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (word_s)
            WORD_DATA:   rdata_s = snapshot_r;
            WORD_STATUS: rdata_s = {cnt16_s, 13'd0, freeze_r, overrun_r, fresh_r};
            WORD_CTRL:   rdata_s = {31'd0, freeze_r};
            default:     rdata_s = 32'h0000_0000;
        endcase
    end

    // Snapshot, flags and counter storage.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            snapshot_r <= 32'h0000_0000;
            fresh_r    <= 1'b0;
            overrun_r  <= 1'b0;
            freeze_r   <= 1'b0;
            cnt_r      <= CNT_W'(0);
        end else begin
            if (capture_s) begin
                snapshot_r <= user_data_in;
            end else begin
                snapshot_r <= snapshot_r;
            end
            fresh_r   <= fresh_next_s;
            overrun_r <= overrun_next_s;
            freeze_r  <= freeze_next_s;
            cnt_r     <= cnt_next_s;
        end
    end

    // Bus outputs: driven only in our own ack cycle so the wired-OR bus stays clean.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= 32'h0000_0000;
        end else begin
            Sl_xferAck <= ack_req_s;
            if (rd_en_s) begin
                Sl_DBus <= to_opb(rdata_s);
            end else begin
                Sl_DBus <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboard bench for the snapshot register: the stimulus process keeps a
// behavioural model and queues the data each accepted transfer must return;
// a negedge monitor pops and compares on every Sl_xferAck.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h0100_3900;
    localparam logic [31:0] HIGH = 32'h0100_39FF;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus, dbus;
    logic [0:3]  be;
    logic        rnw, sel, seqa;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;
    logic [31:0] udata;
    logic        uvalid;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
        .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry),
        .Sl_toutSup(sl_tout), .user_data_in(udata), .user_valid(uvalid)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // reference model state
    logic [31:0] m_snap;
    bit          m_fresh, m_ovr, m_frz, m_busy;
    int          m_cnt;
    bit          ovr_valid = 1'b0;
    logic [31:0] ovr_val;
    bit          rand_user = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_snap = 32'h0; m_fresh = 1'b0; m_ovr = 1'b0; m_frz = 1'b0; m_busy = 1'b0; m_cnt = 0;
    endtask

    // Apply one clock edge worth of behaviour using the current drive values.
    task automatic model_edge();
        logic [31:0] a, wv, rv;
        int w;
        bit accept, cap, dread, wr, c_ovr, c_cnt, n_ovr, n_fresh;
        a = abus; wv = dbus;
        w = int'(a[3:2]);
        accept = sel && (a >= BASE) && (a <= HIGH) && !m_busy;
        cap    = uvalid && !m_frz;
        dread  = accept && rnw && (w == 0);
        case (w)
            0:       rv = m_snap;
            1:       rv = {m_cnt[15:0], 13'd0, m_frz, m_ovr, m_fresh};
            2:       rv = {31'd0, m_frz};
            default: rv = 32'h0;
        endcase
        if (accept) begin
            if (ovr_valid) exp_q.push_back(ovr_val);
            else           exp_q.push_back(rnw ? rv : 32'h0);
            ovr_valid = 1'b0;
        end
        wr    = accept && !rnw && (w == 2) && be[3];
        c_ovr = wr && wv[1];
        c_cnt = wr && wv[2];
        n_ovr   = (m_ovr && !c_ovr) || (cap && m_fresh && !dread);
        n_fresh = cap ? 1'b1 : (dread ? 1'b0 : m_fresh);
        if (c_cnt)    m_cnt = cap ? 1 : 0;
        else if (cap) m_cnt = (m_cnt + 1) % 65536;
        if (cap) m_snap = udata;
        if (wr)  m_frz = wv[0];
        m_ovr = n_ovr; m_fresh = n_fresh;
        if (!sel)        m_busy = 1'b0;
        else if (accept) m_busy = 1'b1;
    endtask

    task automatic cyc();
        if (rand_user) begin
            uvalid = ($urandom_range(0, 2) == 0);
            udata  = $urandom;
        end
        if (!rst) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] addr, input bit r, input logic [31:0] d,
                        input logic [3:0] b, input int hold);
        sel = 1'b1; abus = addr; rnw = r; dbus = d; be = b; seqa = 1'($urandom);
        repeat (hold) cyc();
        sel = 1'b0; abus = 32'h0; dbus = 32'h0; rnw = 1'b0; be = 4'h0;
        cyc();
    endtask

    task automatic rd_exp(input logic [31:0] addr, input logic [31:0] e);
        ovr_valid = 1'b1; ovr_val = e;
        xfer(addr, 1'b1, 32'h0, 4'hF, 2);
    endtask

    task automatic capture(input logic [31:0] d);
        uvalid = 1'b1; udata = d; cyc(); uvalid = 1'b0;
    endtask

    // Monitor: every ack must match the head of the queue; otherwise the bus stays zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (sl_ack) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
                end else begin
                    check("read_data", sl_dbus, exp_q.pop_front());
                end
            end else begin
                check("idle_dbus", sl_dbus, 32'h0);
            end
            check("tied_outputs", {29'd0, sl_err, sl_retry, sl_tout}, 32'h0);
        end
    end

    initial begin
        #(64'd3_000_000);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; abus = 32'h0; dbus = 32'h0; be = 4'h0; rnw = 1'b0;
        seqa = 1'b0; udata = 32'h0; uvalid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, sl_ack}, 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        rst = 1'b0;
        cyc();

        // reset contents
        rd_exp(BASE, 32'h0);
        rd_exp(BASE + 32'h4, 32'h0);

        // single capture, fresh cleared by DATA read
        capture(32'hDEAD_BEEF);
        rd_exp(BASE + 32'h4, 32'h0001_0001);
        rd_exp(BASE, 32'hDEAD_BEEF);
        rd_exp(BASE + 32'h4, 32'h0001_0000);

        // overrun and its W1C clear; counter clear first
        xfer(BASE + 32'h8, 1'b0, 32'h4, 4'hF, 2);
        capture(32'h1);
        capture(32'h2);
        rd_exp(BASE + 32'h4, 32'h0002_0003);
        xfer(BASE + 32'h8, 1'b0, 32'h2, 4'hF, 2);
        rd_exp(BASE + 32'h4, 32'h0002_0001);
        rd_exp(BASE, 32'h2);

        // freeze drops captures
        xfer(BASE + 32'h8, 1'b0, 32'h1, 4'hF, 2);
        capture(32'h55);
        rd_exp(BASE, 32'h2);
        rd_exp(BASE + 32'h4, 32'h0002_0004);
        rd_exp(BASE + 32'h8, 32'h1);
        xfer(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 2);
        rd_exp(BASE + 32'h8, 32'h0);

        // write with LS byte lane disabled is ignored; word 3 reads zero
        xfer(BASE + 32'h8, 1'b0, 32'h1, 4'hE, 2);
        rd_exp(BASE + 32'h8, 32'h0);
        xfer(BASE + 32'hC, 1'b0, 32'hFFFF_FFFF, 4'hF, 2);
        rd_exp(BASE + 32'hC, 32'h0);

        // long select gives one ack; out-of-range addresses are never acked
        rd_exp(BASE + 32'h4, 32'h0002_0000);
        ovr_valid = 1'b1; ovr_val = 32'h0002_0000;
        xfer(BASE + 32'h4, 1'b1, 32'h0, 4'hF, 5);
        xfer(32'h0100_3A00, 1'b1, 32'h0, 4'hF, 3);
        xfer(32'h0100_38FC, 1'b1, 32'h0, 4'hF, 3);

        // master abort: select dropped in the ack cycle, next transfer still works
        xfer(BASE, 1'b1, 32'h0, 4'hF, 1);
        rd_exp(BASE, 32'h2);

        // reset asserted during the ack cycle
        sel = 1'b1; abus = BASE + 32'h4; rnw = 1'b1; be = 4'hF;
        cyc();
        check("ack_before_reset", {31'd0, sl_ack}, 32'h1);
        rst = 1'b1;
        #1;
        check("ack_during_reset", {31'd0, sl_ack}, 32'h0);
        check("dbus_during_reset", sl_dbus, 32'h0);
        exp_q.delete();
        model_reset();
        sel = 1'b0; abus = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        rd_exp(BASE + 32'h4, 32'h0);

        // counter wrap
        uvalid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            udata = 32'(i);
            cyc();
        end
        uvalid = 1'b0;
        rd_exp(BASE + 32'h4, 32'hFFFF_0003);
        capture(32'hA5A5_0000);
        rd_exp(BASE + 32'h4, 32'h0000_0003);
        rd_exp(BASE, 32'hA5A5_0000);

        // randomized traffic against the model
        rand_user = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [31:0] addr;
            case ($urandom_range(0, 6))
                0, 1:    addr = BASE;
                2:       addr = BASE + 32'h4;
                3:       addr = BASE + 32'h8;
                4:       addr = BASE + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                5:       addr = 32'h0100_3A00;
                default: addr = 32'h0100_38F0;
            endcase
            xfer(addr, ($urandom_range(0, 2) != 0), $urandom, 4'($urandom),
                 $urandom_range(1, 3));
        end
        rand_user = 1'b0;
        uvalid = 1'b0;
        rd_exp(BASE + 32'h8, {31'd0, m_frz});

        repeat (3) cyc();
        check("missing_acks", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
